// File: rtl/unshift32.sv
// unshift32: two-stage pipelined 32->16 logical right-shift recovery with flags.
// Optional build macro UNSHIFT32_ROUND_EN selects round-half-up on out_a.
module unshift32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_r,
    input  logic [3:0]  in_dist,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_a,
    output logic        out_ovf,
    output logic        out_inexact
);

    logic        s1_valid;
    logic [31:0] s1_val;
    logic [1:0]  s1_d;
    logic        s1_sticky;
    logic        advance;

    logic [31:0] c1_val;
    logic        c1_sticky;
    logic [31:0] c2_q;
    logic        c2_sticky;
    logic [15:0] c2_a;
    logic        c2_ovf;

`ifdef UNSHIFT32_ROUND_EN
    logic        s1_rnd;
    logic        c1_rnd;
    logic        c2_rbit;
    logic [32:0] c2_sum;
`endif

    // S2 drains or is empty; S1 follows S2 under the same condition
    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;

    // Coarse shift by a multiple of four plus sticky of the dropped nibbles
    always_comb begin
        c1_val    = in_r;
        c1_sticky = 1'b0;
        unique case (in_dist[3:2])
            2'd0: begin
                c1_val    = in_r;
                c1_sticky = 1'b0;
            end
            2'd1: begin
                c1_val    = {4'b0, in_r[31:4]};
                c1_sticky = |in_r[3:0];
            end
            2'd2: begin
                c1_val    = {8'b0, in_r[31:8]};
                c1_sticky = |in_r[7:0];
            end
            2'd3: begin
                c1_val    = {12'b0, in_r[31:12]};
                c1_sticky = |in_r[11:0];
            end
        endcase
    end

`ifdef UNSHIFT32_ROUND_EN
    // Last bit dropped by the coarse shift; it is the round bit when
    // the fine shift distance is zero
    always_comb begin
        c1_rnd = 1'b0;
        unique case (in_dist[3:2])
            2'd0: c1_rnd = 1'b0;
            2'd1: c1_rnd = in_r[3];
            2'd2: c1_rnd = in_r[7];
            2'd3: c1_rnd = in_r[11];
        endcase
    end
`endif

    // Fine shift by 0..3 and final sticky accumulation
    always_comb begin
        c2_q      = s1_val;
        c2_sticky = s1_sticky;
        unique case (s1_d)
            2'd0: begin
                c2_q      = s1_val;
                c2_sticky = s1_sticky;
            end
            2'd1: begin
                c2_q      = {1'b0, s1_val[31:1]};
                c2_sticky = s1_sticky | s1_val[0];
            end
            2'd2: begin
                c2_q      = {2'b0, s1_val[31:2]};
                c2_sticky = s1_sticky | (|s1_val[1:0]);
            end
            2'd3: begin
                c2_q      = {3'b0, s1_val[31:3]};
                c2_sticky = s1_sticky | (|s1_val[2:0]);
            end
        endcase
    end

`ifdef UNSHIFT32_ROUND_EN
    // Round half-up; a carry past bit 15 reports overflow and wraps
    always_comb begin
        c2_rbit = s1_rnd;
        unique case (s1_d)
            2'd0: c2_rbit = s1_rnd;
            2'd1: c2_rbit = s1_val[0];
            2'd2: c2_rbit = s1_val[1];
            2'd3: c2_rbit = s1_val[2];
        endcase
        c2_sum = {1'b0, c2_q} + {32'b0, c2_rbit};
        c2_a   = c2_sum[15:0];
        c2_ovf = |c2_sum[32:16];
    end
`else
    // Truncated result; any surviving high bit is an overflow
    always_comb begin
        c2_a   = c2_q[15:0];
        c2_ovf = |c2_q[31:16];
    end
`endif

    // Stage 1 register: coarse-shifted operand and residual distance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_val    <= '0;
            s1_d      <= '0;
            s1_sticky <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_val    <= c1_val;
                s1_d      <= in_dist[1:0];
                s1_sticky <= c1_sticky;
            end
        end
    end

`ifdef UNSHIFT32_ROUND_EN
    // Round bit carried alongside the stage 1 operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rnd <= 1'b0;
        end else if (in_ready && in_valid) begin
            s1_rnd <= c1_rnd;
        end
    end
`endif

    // Output register: result and flags held stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_ovf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_a       <= c2_a;
                out_ovf     <= c2_ovf;
                out_inexact <= c2_sticky;
            end
        end
    end

endmodule

// File: tb/tb_unshift32.sv
// tb_unshift32: randomized and directed bench for unshift32 against an
// arithmetic reference model with in-order result queue.
module tb_unshift32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_r = '0;
    logic [3:0]  in_dist = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_a;
    logic        out_ovf;
    logic        out_inexact;

    int tests = 0;
    int fails = 0;
    int edges = 0;
    int acc = 0;
    bit chk_en = 1'b0;
    logic [17:0] expq[$];
    int edgeq[$];

    unshift32 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_dist(in_dist),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_ovf(out_ovf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    // Reference: {ovf, inexact, a} from plain arithmetic
    function automatic logic [17:0] model(input logic [31:0] r, input logic [3:0] d);
        longint unsigned q;
        logic inexact;
        q = longint'(r) >> d;
        inexact = (r & ((32'd1 << d) - 32'd1)) != 0;
`ifdef UNSHIFT32_ROUND_EN
        if (d != 0) q = q + ((longint'(r) >> (d - 1)) & 1);
`endif
        return {q > 64'hFFFF, inexact, q[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: every cycle, outputs against the model queue
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_out", {31'b0, out_valid}, 32'd0);
                end else begin
                    check("result", {14'b0, out_ovf, out_inexact, out_a}, {14'b0, expq[0]});
                    check("not_early", {31'b0, (edges - edgeq[0]) >= 1}, 32'd1);
                end
            end else if (expq.size() != 0) begin
                check("no_late", {31'b0, (edges - edgeq[0]) == 0}, 32'd1);
            end
        end
    end

    // One cycle: drive at negedge, record the transfers before the edge
    task automatic step(input bit iv, input logic [31:0] r, input logic [3:0] d, input bit ordy);
        @(negedge clk);
        in_valid  = iv;
        in_r      = r;
        in_dist   = d;
        out_ready = ordy;
        #2;
        if (in_valid && in_ready) begin
            expq.push_back(model(in_r, in_dist));
            edgeq.push_back(edges + 1);
            acc++;
        end
        if (out_valid && out_ready && expq.size() != 0) begin
            void'(expq.pop_front());
            void'(edgeq.pop_front());
        end
    endtask

    logic [15:0] rnd_exp;
    int a0;

    initial begin
        // Pin the model with hand-computed values
        check("model_a00_8", {14'b0, model(32'h0000_0A00, 4'd8)}, 32'h0000A);
        check("model_ovf", {14'b0, model(32'h0001_0000, 4'd0)}, 32'h20000);
`ifdef UNSHIFT32_ROUND_EN
        rnd_exp = 16'd2;
`else
        rnd_exp = 16'd1;
`endif
        check("model_3_1", {14'b0, model(32'h3, 4'd1)}, {14'b0, 2'b01, rnd_exp});

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_a", {16'b0, out_a}, 32'd0);
        check("rst_flags", {30'b0, out_ovf, out_inexact}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", {31'b0, in_ready}, 32'd1);
        chk_en = 1'b1;

        // Exact two-cycle latency
        step(1, 32'h0000_0A00, 4'd8, 1);
        step(0, 32'hDEAD_BEEF, 4'd3, 1);
        check("lat_not_1", {31'b0, out_valid}, 32'd0);
        step(0, 32'hDEAD_BEEF, 4'd3, 1);
        check("lat_valid", {31'b0, out_valid}, 32'd1);
        check("lat_a", {16'b0, out_a}, 32'h000A);
        check("lat_flags", {30'b0, out_ovf, out_inexact}, 32'd0);

        // Overflow and inexact corners
        step(1, 32'h0001_0000, 4'd0, 1);
        step(1, 32'h0000_0003, 4'd1, 1);
        step(0, 0, 0, 1);
        check("ovf_a", {16'b0, out_a}, 32'd0);
        check("ovf_flag", {31'b0, out_ovf}, 32'd1);
        step(0, 0, 0, 1);
        check("inx_a", {16'b0, out_a}, {16'b0, rnd_exp});
        check("inx_flag", {31'b0, out_inexact}, 32'd1);

        // Back-to-back k<<k by k
        for (int k = 0; k < 18; k++) begin
            step(k < 16, 32'(k) << k, 4'(k), 1);
            if (k >= 2) begin
                check("b2b_valid", {31'b0, out_valid}, 32'd1);
                check("b2b_a", {16'b0, out_a}, k - 2);
                check("b2b_flags", {30'b0, out_ovf, out_inexact}, 32'd0);
            end
        end

        // Stall five cycles while streaming
        a0 = acc;
        for (int k = 0; k < 5; k++) step(1, 32'h100 * (acc + 1), 4'd4, 0);
        check("stall_accepts", acc - a0, 32'd2);
        check("stall_ready", {31'b0, in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) step(k < 2, 32'h100 * (acc + 1), 4'd4, 1);
        check("stall_drain", expq.size(), 32'd0);

        // Reset with both stages full
        for (int k = 0; k < 3; k++) step(1, 32'h1234_5678, 4'd2, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_a", {16'b0, out_a}, 32'd0);
        expq.delete();
        edgeq.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
        check("no_stale", {31'b0, out_valid}, 32'd0);

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 6; k++) step(0, 0, 0, 1);
        check("final_drain", expq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unshift32.md
UNSHIFT32 -- requirements
Module: unshift32

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  in_r/in_dist hold a valid operand this cycle.
REQ-005 in_ready  output  1  block accepts the operand this cycle.
REQ-006 in_r  input  32  shifted value to be recovered.
REQ-007 in_dist  input  4  right-shift distance, 0..15.
REQ-008 out_valid  output  1  out_a/out_ovf/out_inexact hold a valid result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_a  output  16  recovered operand.
REQ-011 out_ovf  output  1  shifted value does not fit in 16 bits.
REQ-012 out_inexact  output  1  nonzero bits were shifted out.

Function
REQ-013 The block SHALL compute q = in_r >> in_dist (logical, zero fill); out_a = q[15:0]; out_ovf = |q[31:16]; out_inexact = |(in_r & ((1<<in_dist)-1)).
REQ-014 Transfers: input on in_valid&&in_ready at an edge; output on out_valid&&out_ready at an edge.
REQ-015 The pipeline SHALL have two register stages: S1 registers in_r>>(4*in_dist[3:2]), in_dist[1:0] and a partial sticky bit; S2 (output) registers the shift by in_dist[1:0], the final flags and out_valid.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no stall; throughput SHALL be one result per cycle while out_ready=1.
REQ-017 S2 SHALL load when !out_valid || out_ready; S1 SHALL advance into S2 under the same condition.
REQ-018 in_ready SHALL equal !s1_valid || !out_valid || out_ready; it SHALL not depend combinationally on in_valid.
REQ-019 While out_valid=1 and out_ready=0, out_a/out_ovf/out_inexact SHALL remain stable and no accepted operand SHALL be lost or duplicated.
REQ-020 Simultaneous input and output transfers in one cycle SHALL both complete; pipeline occupancy stays unchanged.
REQ-021 in_dist=0 SHALL pass in_r through unchanged (out_inexact=0).
REQ-022 in_r/in_dist SHALL be ignored when in_valid=0; bubbles SHALL propagate as out_valid=0.

Reset
REQ-023 rst_n=0 SHALL immediately clear s1_valid and out_valid, and set out_a=0, out_ovf=0, out_inexact=0, regardless of clk.
REQ-024 Reset mid-operation SHALL discard all in-flight operands; no result SHALL emerge after deassertion.
REQ-025 in_ready SHALL be 1 in the first cycle after rst_n rises.

Configuration
REQ-026 Macro UNSHIFT32_ROUND_EN defined: out_a SHALL be q rounded half-up (q + in_r[in_dist-1] when in_dist>0), out_ovf SHALL be set if the rounded value exceeds 16'hFFFF (out_a then wraps to its low 16 bits); out_inexact unchanged.
REQ-027 Macro undefined: out_a SHALL be q truncated per REQ-013; latency and handshake identical in both builds.

Verification
REQ-028 in_r=32'h0000_0A00, in_dist=8, out_ready=1 -> 2 cycles later out_a=16'h000A, out_ovf=0, out_inexact=0.
REQ-029 in_r=32'h0001_0000, in_dist=0 -> out_a=0, out_ovf=1; in_r=32'h0000_0003, in_dist=1 -> out_a=1 (2 with UNSHIFT32_ROUND_EN), out_inexact=1.
REQ-030 16 back-to-back operands in_r=k<<k, in_dist=k (k=0..15), out_ready=1 -> 16 consecutive results out_a=k, no gaps, flags 0.
REQ-031 Hold out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 accepts, out_a stable, all operands later delivered in order.
REQ-032 Assert rst_n=0 with both stages full -> out_valid=0 immediately, out_a=0, no stale result after release.
REQ-033 Random in_r/in_dist with random in_valid/out_ready over 10000 cycles -> every result matches REQ-013 model in order.
